// File: rtl/fs_serial_nbits.sv
// Bit-serial N-bit full subtractor: A - B - bin, one bit per clock, LSB first, start/done handshake.
// Optional signed-overflow output enabled by defining FS_SERIAL_OVF_EN.
module fs_serial_nbits #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  fs_serial_clk,
  input  logic                  fs_serial_rst,
  input  logic                  fs_serial_start,
  input  logic                  fs_serial_bin,
  input  logic [DATA_WIDTH-1:0] fs_serial_port_a,
  input  logic [DATA_WIDTH-1:0] fs_serial_port_b,
  output logic                  fs_serial_busy,
  output logic                  fs_serial_done,
  output logic [DATA_WIDTH-1:0] fs_serial_port_diff,
  output logic                  fs_serial_port_bout
`ifdef FS_SERIAL_OVF_EN
  ,
  output logic                  fs_serial_ovf
`endif
);

  localparam int CW = (DATA_WIDTH < 1) ? 1 : $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic                  br_q, br_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] diff_q, diff_d;
  logic                  bout_q, bout_d;

  logic                  bit_diff;
  logic                  br_next;
  logic                  last_bit;
  logic [DATA_WIDTH-1:0] d_msb;
  logic [DATA_WIDTH-1:0] wd_shift;

`ifdef FS_SERIAL_OVF_EN
  logic sign_a_q, sign_a_d;
  logic sign_b_q, sign_b_d;
  logic ovf_q, ovf_d;
`endif

  // Single-bit full-subtractor slice on the current LSBs.
  always_comb begin
    bit_diff = a_q[0] ^ b_q[0] ^ br_q;
    br_next  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    d_msb    = '0;
    d_msb[DATA_WIDTH-1] = bit_diff;
    wd_shift = (wd_q >> 1) | d_msb;
    last_bit = (cnt_q == CW'(DATA_WIDTH - 1));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    wd_d    = wd_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef FS_SERIAL_OVF_EN
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    ovf_d    = ovf_q;
`endif

    case (state_q)
      // DONE accepts a new start exactly like IDLE, giving back-to-back operation.
      S_IDLE, S_DONE: begin
        if (fs_serial_start) begin
          a_d     = fs_serial_port_a;
          b_d     = fs_serial_port_b;
          br_d    = fs_serial_bin;
          wd_d    = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
`ifdef FS_SERIAL_OVF_EN
          sign_a_d = fs_serial_port_a[DATA_WIDTH-1];
          sign_b_d = fs_serial_port_b[DATA_WIDTH-1];
`endif
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_next;
        wd_d  = wd_shift;
        cnt_d = cnt_q + CW'(1);
        if (last_bit) begin
          diff_d  = wd_shift;
          bout_d  = br_next;
          state_d = S_DONE;
`ifdef FS_SERIAL_OVF_EN
          ovf_d = (sign_a_q != sign_b_q) && (wd_shift[DATA_WIDTH-1] != sign_a_q);
`endif
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge fs_serial_clk) begin
    if (fs_serial_rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      wd_q    <= '0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      wd_q    <= wd_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

`ifdef FS_SERIAL_OVF_EN
  always_ff @(posedge fs_serial_clk) begin
    if (fs_serial_rst) begin
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      ovf_q    <= ovf_d;
    end
  end

  assign fs_serial_ovf = ovf_q;
`endif

  assign fs_serial_busy      = (state_q == S_SHIFT);
  assign fs_serial_done      = (state_q == S_DONE);
  assign fs_serial_port_diff = diff_q;
  assign fs_serial_port_bout = bout_q;

endmodule

// File: tb/tb_fs_serial_nbits.sv
// Self-checking bench for fs_serial_nbits: directed table, handshake corner cases, random vs. arithmetic model.
module tb_fs_serial_nbits;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         bin;
  logic [N-1:0] port_a, port_b;
  logic         busy, done, bout;
  logic [N-1:0] diff;
`ifdef FS_SERIAL_OVF_EN
  logic         ovf;
`endif

  int n_vec = 0;
  int n_cmp = 0;
  int n_bad = 0;

  // Result the outputs should currently be holding.
  logic [N-1:0] held_diff = '0;
  logic         held_bout = 1'b0;
  logic         held_ovf  = 1'b0;

  fs_serial_nbits #(.DATA_WIDTH(N)) dut (
    .fs_serial_clk      (clk),
    .fs_serial_rst      (rst),
    .fs_serial_start    (start),
    .fs_serial_bin      (bin),
    .fs_serial_port_a   (port_a),
    .fs_serial_port_b   (port_b),
    .fs_serial_busy     (busy),
    .fs_serial_done     (done),
    .fs_serial_port_diff(diff),
    .fs_serial_port_bout(bout)
`ifdef FS_SERIAL_OVF_EN
    ,
    .fs_serial_ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic [N-1:0] diff;
    logic         bout;
    logic         ovf;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic on the operand values.
  task automatic model(input logic [N-1:0] a, input logic [N-1:0] b, input logic bi,
                       output logic [N-1:0] d, output logic bo, output logic ov);
    int unsigned full;
    full = (int'(a) + (1 << N) - int'(b) - int'(bi)) % (1 << N);
    d  = full[N-1:0];
    bo = (int'(a) < int'(b) + int'(bi));
    ov = (a[N-1] != b[N-1]) && (d[N-1] != a[N-1]);
  endtask

  // Runs one operation. If chained, we are sitting in a done cycle and start at once.
  // glitch >= 0 pulses start with junk operands that many cycles into SHIFT.
  task automatic do_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic bi, input logic [N-1:0] ed, input logic eb, input logic eo,
                       input bit chained, input int glitch);
    int lat;
    if (!chained) begin
      @(negedge clk);
      chk({name, ".idle_done"}, int'(done), 0);
      chk({name, ".idle_busy"}, int'(busy), 0);
    end
    start = 1'b1; port_a = a; port_b = b; bin = bi;
    @(negedge clk);
    start = 1'b0;
    port_a = N'($urandom); port_b = N'($urandom); bin = 1'($urandom);
    lat = 0;
    while (!done && lat < 4 * N + 8) begin
      chk({name, ".busy"}, int'(busy), 1);
      chk({name, ".diff_hold"}, int'(diff), int'(held_diff));
      start = (lat == glitch) ? 1'b1 : 1'b0;
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    n_vec++;
    chk({name, ".latency"}, lat, N);
    chk({name, ".diff"}, int'(diff), int'(ed));
    chk({name, ".bout"}, int'(bout), int'(eb));
    chk({name, ".busy_at_done"}, int'(busy), 0);
`ifdef FS_SERIAL_OVF_EN
    chk({name, ".ovf"}, int'(ovf), int'(eo));
`endif
    held_diff = ed; held_bout = eb; held_ovf = eo;
    $display("op %-10s a=%02h b=%02h bin=%0d -> diff=%02h bout=%0d lat=%0d",
             name, a, b, bi, diff, bout, lat);
  endtask

  vec_t tbl[8];

  initial begin
    logic [N-1:0] ra, rb, rd;
    logic rbi, rbo, rov;
    int seen;

    tbl[0] = '{8'h05, 8'h0E, 1'b0, 8'hF7, 1'b1, 1'b0};
    tbl[1] = '{8'h0E, 8'h05, 1'b0, 8'h09, 1'b0, 1'b0};
    tbl[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    tbl[4] = '{8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0};
    tbl[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[6] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0};
    tbl[7] = '{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; bin = 1'b0; port_a = '0; port_b = '0;
    repeat (3) @(negedge clk);
    chk("reset.busy", int'(busy), 0);
    chk("reset.done", int'(done), 0);
    chk("reset.diff", int'(diff), 0);
    chk("reset.bout", int'(bout), 0);
`ifdef FS_SERIAL_OVF_EN
    chk("reset.ovf", int'(ovf), 0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      do_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].bin,
            tbl[i].diff, tbl[i].bout, tbl[i].ovf, 1'b0, -1);

    // Start mid-operation with other operands must be ignored.
    do_op("ignore", 8'h05, 8'h0E, 1'b0, 8'hF7, 1'b1, 1'b0, 1'b0, 3);

    // Start during the done cycle: accepted with no bubble.
    do_op("b2b_a", 8'h3C, 8'h21, 1'b1, 8'h1A, 1'b0, 1'b0, 1'b0, -1);
    do_op("b2b_b", 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0, 1'b1, -1);
    @(negedge clk);
    chk("b2b.done_drop", int'(done), 0);

    // Reset four edges into an operation aborts it with no done pulse.
    start = 1'b1; port_a = 8'h99; port_b = 8'h11; bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.busy", int'(busy), 0);
    chk("abort.done", int'(done), 0);
    chk("abort.diff", int'(diff), 0);
    chk("abort.bout", int'(bout), 0);
    seen = 0;
    for (int i = 0; i < 2 * N; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("abort.no_done", seen, 0);
    held_diff = '0; held_bout = 1'b0; held_ovf = 1'b0;
    do_op("post_rst", 8'h0E, 8'h05, 1'b0, 8'h09, 1'b0, 1'b0, 1'b0, -1);

    // Reset wins over start on the same edge.
    start = 1'b1; rst = 1'b1; port_a = 8'h42;
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    chk("rst_prio.busy", int'(busy), 0);
    chk("rst_prio.diff", int'(diff), 0);
    held_diff = '0;

    for (int i = 0; i < 40; i++) begin
      ra = N'($urandom); rb = N'($urandom); rbi = 1'($urandom);
      if (i % 8 == 0) ra = '0;
      if (i % 8 == 1) rb = '1;
      model(ra, rb, rbi, rd, rbo, rov);
      do_op($sformatf("rnd%0d", i), ra, rb, rbi, rd, rbo, rov, 1'($urandom), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fs_serial_nbits.md
Name: fs_serial_nbits

Overview:
Bit-serial N-bit full subtractor computing A − B − borrow_in, one bit per clock, LSB first. It is the subtract-direction counterpart of the team's N-bit ripple full adder. It shares the same operand/carry port style, but trades area for latency with a single borrow flip-flop and start/done handshake. It feeds the lab ALU datapath and board-level demo on the NEXYS A7 100T.

Parameters:
DATA_WIDTH, 8, operand and difference width in bits (legal ≥ 1)

Ports:
fs_serial_clk  input  1  system clock, rising-edge
fs_serial_rst  input  1  synchronous, active-high reset
fs_serial_start  input  1  request; sampled on rising edge when not busy
fs_serial_bin  input  1  borrow in, captured with start
fs_serial_port_a  input  DATA_WIDTH  minuend, captured with start
fs_serial_port_b  input  DATA_WIDTH  subtrahend, captured with start
fs_serial_busy  output  1  high while bits are being processed
fs_serial_done  output  1  one-cycle pulse, result valid
fs_serial_port_diff  output  DATA_WIDTH  registered difference, held until next completion
fs_serial_port_bout  output  1  registered borrow out, held until next completion
fs_serial_ovf  output  1  signed overflow; port present only with FS_SERIAL_OVF_EN

Behaviour:
- One clock; reset synchronous, active-high. In reset: state=IDLE, busy=0, done=0, diff=0, bout=0, ovf=0, internal shift regs/counter/borrow=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: start=1 at edge t → capture A, B, bin into shift regs/borrow FF, counter=0, go SHIFT. start=0 → stay.
- SHIFT: busy=1. Edges t+1 .. t+N (N=DATA_WIDTH), one bit per edge:
  - d = a0 ^ b0 ^ br
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
  - shift A, B right; shift d into working diff reg at MSB.
- Bit N is processed at edge t+N. On that edge:
  - load fs_serial_port_diff and fs_serial_port_bout from the final values;
  - set done=1, busy=0, and go to DONE.
- Result latency: done is high during the cycle after edge t+N, which is N edges after the start-sample edge.
- DONE lasts exactly one cycle, with done=1.
  - start=1 in DONE: new capture, go SHIFT (back-to-back, no bubble).
  - Otherwise go to IDLE. done returns to 0 at the next edge either way.
- start while in SHIFT is ignored; captured operands are not disturbed.
- Operand inputs may change freely after the capture edge.
- diff/bout outputs change only at completion and stay stable while busy.
- Arithmetic: result is modulo 2^N. bout=1 iff unsigned A < B + bin.
- N=1: capture at t, done after edge t+1.
- Reset mid-operation: abort immediately. No done pulse; outputs return to reset values.
- Reset has priority over start on the same edge.
- Counter width: ceil(log2(N+1)) bits, no wrap inside a legal operation.

Optional Feature:
FS_SERIAL_OVF_EN
- Defined:
  - Port fs_serial_ovf exists.
  - It is registered at completion alongside diff as (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]), using the captured operands (sign bits saved at capture).
  - It is held until the next completion; reset value 0. bin is included in diff.
- Undefined: port and sign-capture logic absent; all other behaviour identical.

Test Plan:
- N=8, A=0x05, B=0x0E, bin=0, start pulse at edge t → busy high edges t..t+8; done single pulse after edge t+8; diff=0xF7, bout=1.
- A=0x0E, B=0x05, bin=0 → diff=0x09, bout=0; A=0x00, B=0x00, bin=1 → diff=0xFF, bout=1.
- With FS_SERIAL_OVF_EN: A=0x80, B=0x01, bin=0 → diff=0x7F, bout=0, ovf=1; A=0x7F, B=0x01 → diff=0x7E, ovf=0.
- Busy/back-to-back: second start with new operands 3 cycles after the first → ignored, first result correct. start asserted during the done cycle → second op accepted; its done follows exactly 8 edges later.
- Reset asserted 4 edges into an operation → next cycle busy=0, done=0, diff=0, bout=0, no done pulse follows. A fresh start afterwards completes normally.
- DATA_WIDTH=1 build: A=0, B=1, bin=0 → done after 1 edge, diff=1, bout=1.
